dmem_arbiter: RTL and testbench

// - Shares the single data_memory port between two requesters: port 0 (core load/store unit) and port 1 (debug/DMA).
// - Round-robin arbitration; valid/ready request handshake; registered 1-cycle response pulse.
// - Drives the memory's read/write address, data, write-enable and size/extend controls; captures its combinational read data.

---
 rtl/dmem_arbiter.sv | 152 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data_memory port between two requesters.
//   Port 0 = core load/store unit, port 1 = debug/DMA. Round-robin arbitration
//   with a valid/ready request handshake and a registered 1-cycle response.
//   One access takes three cycles: IDLE (accept) -> ACCESS (memory) -> RESP.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   reqN_valid/ready            request handshake (ready only in IDLE)
//   reqN_addr/wdata/we          byte address, store data, 1 = store
//   reqN_byte/half/zext         access size (both set = word), zero-extend load
//   rspN_valid/rdata/err        one-cycle response; rdata is 0 for stores
//   mem_*                       memory controls, all 0 outside ACCESS
//   mem_readData                combinational read data from the memory
// Build option: DMEM_ARB_ALIGN_CHECK_EN enables misalignment detection
//   (misaligned access: no write, rspN_err=1, rspN_rdata=0).
module dmem_arbiter #(
  parameter int BIT_WIDTH  = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [BIT_WIDTH-1:0]  req0_wdata,
  input  logic                  req0_we,
  input  logic                  req0_byte,
  input  logic                  req0_half,
  input  logic                  req0_zext,
  output logic                  rsp0_valid,
  output logic [BIT_WIDTH-1:0]  rsp0_rdata,
  output logic                  rsp0_err,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [BIT_WIDTH-1:0]  req1_wdata,
  input  logic                  req1_we,
  input  logic                  req1_byte,
  input  logic                  req1_half,
  input  logic                  req1_zext,
  output logic                  rsp1_valid,
  output logic [BIT_WIDTH-1:0]  rsp1_rdata,
  output logic                  rsp1_err,
  output logic [ADDR_WIDTH-1:0] mem_readAddr,
  output logic [ADDR_WIDTH-1:0] mem_writeAddr,
  output logic [BIT_WIDTH-1:0]  mem_writeData,
  output logic                  mem_writeEn,
  output logic                  mem_addr_byte,
  output logic                  mem_addr_half,
  output logic                  mem_zero_extend,
  input  logic [BIT_WIDTH-1:0]  mem_readData
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [BIT_WIDTH-1:0]  wdata;
    logic                  we;
    logic                  bsz;
    logic                  hsz;
    logic                  zext;
  } req_t;

  state_e               state_q;
  req_t                 req_q;
  logic                 win_q, last_grant_q;
  logic [1:0]           rsp_valid_q;
  logic [BIT_WIDTH-1:0] rsp_rdata_q;
  logic                 rsp_err_q;

  req_t r0, r1, sel_d;
  logic grant, win_d;
  logic in_acc, is_byte, is_half, misalign;

  assign r0 = '{addr: req0_addr, wdata: req0_wdata, we: req0_we,
                bsz: req0_byte, hsz: req0_half, zext: req0_zext};
  assign r1 = '{addr: req1_addr, wdata: req1_wdata, we: req1_we,
                bsz: req1_byte, hsz: req1_half, zext: req1_zext};

  // Winner: the only valid port, or the one not granted last time on a tie.
  assign grant = (state_q == IDLE) & (req0_valid | req1_valid) & ~rst;
  assign win_d = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
  assign sel_d = win_d ? r1 : r0;

  assign req0_ready = grant & ~win_d;
  assign req1_ready = grant &  win_d;

  // byte and half both set degrade to a word access.
  assign is_byte = req_q.bsz & ~req_q.hsz;
  assign is_half = req_q.hsz & ~req_q.bsz;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  assign misalign = (is_half & req_q.addr[0]) |
                    (~is_byte & ~is_half & (|req_q.addr[1:0]));
`else
  assign misalign = 1'b0;
`endif

  assign in_acc          = (state_q == ACCESS);
  assign mem_readAddr    = in_acc ? req_q.addr  : '0;
  assign mem_writeAddr   = in_acc ? req_q.addr  : '0;
  assign mem_writeData   = in_acc ? req_q.wdata : '0;
  // rst in ACCESS must stop the write landing at this posedge.
  assign mem_writeEn     = in_acc & req_q.we & ~misalign & ~rst;
  assign mem_addr_byte   = in_acc & is_byte;
  assign mem_addr_half   = in_acc & is_half;
  assign mem_zero_extend = in_acc & req_q.zext;

  assign rsp0_valid = rsp_valid_q[0];
  assign rsp1_valid = rsp_valid_q[1];
  assign rsp0_rdata = rsp_valid_q[0] ? rsp_rdata_q : '0;
  assign rsp1_rdata = rsp_valid_q[1] ? rsp_rdata_q : '0;
  assign rsp0_err   = rsp_valid_q[0] & rsp_err_q;
  assign rsp1_err   = rsp_valid_q[1] & rsp_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      req_q        <= '0;
      win_q        <= 1'b0;
      last_grant_q <= 1'b1;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant) begin
            req_q   <= sel_d;
            win_q   <= win_d;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          rsp_valid_q <= win_q ? 2'b10 : 2'b01;
          rsp_rdata_q <= (req_q.we | misalign) ? '0 : mem_readData;
          rsp_err_q   <= misalign;
          state_q     <= RESP;
        end
        RESP: begin
          rsp_valid_q  <= '0;
          rsp_rdata_q  <= '0;
          rsp_err_q    <= 1'b0;
          last_grant_q <= win_q;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a little-endian byte-addressed
// memory model (64 words) that performs sub-word selection and extension.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_we, req0_byte, req0_half, req0_zext;
  logic [31:0] req0_addr, req0_wdata;
  logic        rsp0_valid, rsp0_err;
  logic [31:0] rsp0_rdata;
  logic        req1_valid, req1_ready, req1_we, req1_byte, req1_half, req1_zext;
  logic [31:0] req1_addr, req1_wdata;
  logic        rsp1_valid, rsp1_err;
  logic [31:0] rsp1_rdata;
  logic [31:0] mem_readAddr, mem_writeAddr, mem_writeData, mem_readData;
  logic        mem_writeEn, mem_addr_byte, mem_addr_half, mem_zero_extend;

  int npass = 0;
  int ntotal = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.BIT_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_we(req0_we), .req0_byte(req0_byte),
    .req0_half(req0_half), .req0_zext(req0_zext), .rsp0_valid(rsp0_valid),
    .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_we(req1_we), .req1_byte(req1_byte),
    .req1_half(req1_half), .req1_zext(req1_zext), .rsp1_valid(rsp1_valid),
    .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .mem_readAddr(mem_readAddr), .mem_writeAddr(mem_writeAddr),
    .mem_writeData(mem_writeData), .mem_writeEn(mem_writeEn),
    .mem_addr_byte(mem_addr_byte), .mem_addr_half(mem_addr_half),
    .mem_zero_extend(mem_zero_extend), .mem_readData(mem_readData)
  );

  // ---------------- memory model ----------------
  logic [31:0] mem [64] = '{default: 32'h0};
  logic        tb_we = 1'b0;
  logic [31:0] tb_wa = '0, tb_wd = '0;
  logic [31:0] rword, wword, wnext;
  logic [7:0]  rb;
  logic [15:0] rh;

  always_comb begin
    rword = mem[mem_readAddr[7:2]];
    rb    = rword[8*mem_readAddr[1:0] +: 8];
    rh    = rword[16*mem_readAddr[1] +: 16];
    if (mem_addr_byte)
      mem_readData = mem_zero_extend ? {24'h0, rb} : {{24{rb[7]}}, rb};
    else if (mem_addr_half)
      mem_readData = mem_zero_extend ? {16'h0, rh} : {{16{rh[15]}}, rh};
    else
      mem_readData = rword;
    wword = mem[mem_writeAddr[7:2]];
    wnext = wword;
    if (mem_addr_byte)      wnext[8*mem_writeAddr[1:0] +: 8] = mem_writeData[7:0];
    else if (mem_addr_half) wnext[16*mem_writeAddr[1] +: 16] = mem_writeData[15:0];
    else                    wnext = mem_writeData;
  end

  always @(posedge clk) begin
    if (tb_we)       mem[tb_wa[7:2]] <= tb_wd;
    if (mem_writeEn) mem[mem_writeAddr[7:2]] <= wnext;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic poke(input logic [31:0] a, input logic [31:0] d);
    tb_wa = a; tb_wd = d; tb_we = 1'b1;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic drive(input bit p, input logic [31:0] a, input logic [31:0] wd,
                       input bit we, input bit b, input bit h, input bit z);
    if (p) begin
      req1_valid = 1; req1_addr = a; req1_wdata = wd; req1_we = we;
      req1_byte = b; req1_half = h; req1_zext = z;
    end else begin
      req0_valid = 1; req0_addr = a; req0_wdata = wd; req0_we = we;
      req0_byte = b; req0_half = h; req0_zext = z;
    end
  endtask

  // Full transaction from a negedge in IDLE; returns at a negedge in IDLE.
  task automatic xfer(input string tag, input bit p, input logic [31:0] a,
                      input logic [31:0] wd, input bit we, input bit b, input bit h,
                      input bit z, input logic [31:0] exp_rd, input bit exp_err,
                      input bit exp_wen);
    drive(p, a, wd, we, b, h, z);
    #1;
    chk({tag, "_ready"}, p ? req1_ready : req0_ready, 1);
    chk({tag, "_other_ready"}, p ? req0_ready : req1_ready, 0);
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    #1;
    chk({tag, "_wen"}, mem_writeEn, exp_wen);
    chk({tag, "_addr"}, mem_readAddr, a);
    @(negedge clk);
    #1;
    chk({tag, "_rsp_valid"}, p ? rsp1_valid : rsp0_valid, 1);
    chk({tag, "_other_rsp"}, p ? rsp0_valid : rsp1_valid, 0);
    chk({tag, "_rdata"}, p ? rsp1_rdata : rsp0_rdata, exp_rd);
    chk({tag, "_err"}, p ? rsp1_err : rsp0_err, exp_err);
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] gseq;
    int nr0, nr1, nrdy, nboth;
    rst = 1;
    req0_valid = 0; req0_addr = 0; req0_wdata = 0; req0_we = 0;
    req0_byte = 0; req0_half = 0; req0_zext = 0;
    req1_valid = 0; req1_addr = 0; req1_wdata = 0; req1_we = 0;
    req1_byte = 0; req1_half = 0; req1_zext = 0;
    repeat (2) @(negedge clk);
    rst = 0;

    // Reset state and 5 idle cycles: every output low.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("idle_ctrl", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err,
                        rsp1_err, mem_writeEn, mem_addr_byte, mem_addr_half,
                        mem_zero_extend}, 0);
      chk("idle_data", |{rsp0_rdata, rsp1_rdata, mem_readAddr, mem_writeAddr,
                         mem_writeData}, 0);
    end
    @(negedge clk);

    // Port 0 word store then load.
    xfer("st_word", 0, 32'h10, 32'hDEADBEEF, 1, 0, 0, 0, 32'h0, 0, 1);
    chk("st_word_mem", mem[4], 32'hDEADBEEF);
    xfer("ld_word", 0, 32'h10, 32'h0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0);

    // Port 1 byte loads, signed and zero-extended.
    poke(32'h20, 32'h80FF0000);
    xfer("ld_sb", 1, 32'h23, 32'h0, 0, 1, 0, 0, 32'hFFFFFF80, 0, 0);
    xfer("ld_ub", 1, 32'h23, 32'h0, 0, 1, 0, 1, 32'h00000080, 0, 0);

    // Half store into upper half of a word.
    poke(32'h10, 32'h11223344);
    xfer("st_half", 0, 32'h12, 32'h0000ABCD, 1, 0, 1, 0, 32'h0, 0, 1);
    chk("st_half_mem", mem[4], 32'hABCD3344);
    // byte+half together behave as a word.
    xfer("ld_bh", 1, 32'h10, 32'h0, 0, 1, 1, 0, 32'hABCD3344, 0, 0);

    // Round-robin with both ports valid for 12 cycles (last grant was port 1).
    gseq = '0; nr0 = 0; nr1 = 0; nrdy = 0; nboth = 0;
    drive(0, 32'h10, 32'h0, 0, 0, 0, 0);
    drive(1, 32'h20, 32'h0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (req0_ready && req1_ready) nboth++;
      if (req0_ready) begin gseq = {gseq[2:0], 1'b0}; nrdy++; end
      if (req1_ready) begin gseq = {gseq[2:0], 1'b1}; nrdy++; end
      if (rsp0_valid) begin nr0++; chk("rr_rdata0", rsp0_rdata, 32'hABCD3344); end
      if (rsp1_valid) begin nr1++; chk("rr_rdata1", rsp1_rdata, 32'h80FF0000); end
    end
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    chk("rr_grant_seq", gseq, 4'b0101);
    chk("rr_ready_cnt", nrdy, 4);
    chk("rr_both_ready", nboth, 0);
    chk("rr_rsp0_cnt", nr0, 2);
    chk("rr_rsp1_cnt", nr1, 2);

    // rst during ACCESS of a store: no write, no response.
    poke(32'h30, 32'h5555AAAA);
    drive(0, 32'h30, 32'h12345678, 1, 0, 0, 0);
    #1;
    chk("rstacc_ready", req0_ready, 1);
    @(negedge clk);
    req0_valid = 0; rst = 1;
    #1;
    chk("rstacc_wen", mem_writeEn, 0);
    @(negedge clk);
    rst = 0;
    #1;
    chk("rstacc_rsp", rsp0_valid, 0);
    chk("rstacc_mem", mem[12], 32'h5555AAAA);
    @(negedge clk); #1;
    chk("rstacc_rsp2", rsp0_valid, 0);
    @(negedge clk);

    // rst during RESP: the response pulse drops in the next cycle.
    drive(1, 32'h30, 32'h0, 0, 0, 0, 0);
    @(negedge clk);
    req1_valid = 0;
    @(negedge clk); #1;
    chk("rstrsp_valid", rsp1_valid, 1);
    chk("rstrsp_rdata", rsp1_rdata, 32'h5555AAAA);
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
    chk("rstrsp_drop", rsp1_valid, 0);
    @(negedge clk);

    // Misaligned word store.
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    xfer("mis_st", 1, 32'h33, 32'h0BADF00D, 1, 0, 0, 0, 32'h0, 1, 0);
    chk("mis_mem", mem[12], 32'h5555AAAA);
`else
    xfer("mis_st", 1, 32'h33, 32'h0BADF00D, 1, 0, 0, 0, 32'h0, 0, 1);
    chk("mis_mem", mem[12], 32'h0BADF00D);
`endif

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
